// File: rtl/crc_qsys_mem_crc_reader.sv
// Avalon-MM read master computing IEEE CRC-32 over a block of memory words.
// Define CRC_QSYS_MEM_CRC_READER_TIMEOUT_EN to enable the stall timeout.
module crc_qsys_mem_crc_reader #(
  parameter int ADDR_W         = 10,
  parameter int MAX_PENDING    = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic              busy,
  output logic              done,
  output logic [31:0]       crc_out,
  output logic              error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam logic [31:0] POLY = 32'hEDB88320;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_num;
  logic [ADDR_W:0]   r_issue;
  logic [ADDR_W:0]   r_recv;
  logic [3:0]        r_pend;
  logic [31:0]       r_crc;
  logic [31:0]       r_crc_out;

  logic            w_idle;
  logic            w_run;
  logic            w_fin;
  logic            w_acc;
  logic            w_ret;
  logic            w_last;
  logic            w_timeout;
  logic [ADDR_W:0] w_recv_nxt;
  logic [31:0]     w_crc_nxt;

  // Bits enter LSB first: byte 0 bit 0 up to byte 3 bit 7.
  function automatic logic [31:0] crc32_step(
    input logic [31:0] c,
    input logic [31:0] d
  );
    logic [31:0] r;
    logic        b;
    r = c;
    for (int i = 0; i < 32; i++) begin
      b = r[0] ^ d[i];
      r = r >> 1;
      if (b) r = r ^ POLY;
    end
    return r;
  endfunction

  assign w_idle = (r_state == S_IDLE);
  assign w_run  = (r_state == S_RUN);
  assign w_fin  = (r_state == S_FINISH);

  assign avm_read = w_run
                  && (r_issue < r_num)
                  && (r_pend < 4'(MAX_PENDING));
  assign avm_address    = r_addr;
  assign avm_byteenable = 4'b1111;

  assign w_acc      = avm_read & ~avm_waitrequest;
  assign w_ret      = w_run & avm_readdatavalid;
  assign w_recv_nxt = r_recv + (ADDR_W+1)'(w_ret);
  assign w_crc_nxt  = w_ret ? crc32_step(r_crc, avm_readdata)
                            : r_crc;
  assign w_last     = w_run && (w_recv_nxt == r_num);

  assign busy    = w_run;
  assign done    = w_fin;
  assign crc_out = r_crc_out;

`ifdef CRC_QSYS_MEM_CRC_READER_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SW-1:0] r_stall;
  logic          r_err;

  assign w_timeout = w_run && !w_acc && !w_ret
                  && (r_stall == SW'(TIMEOUT_CYCLES - 1));
  assign error = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (1'b1)
        w_idle: begin
          if (start) begin
            r_stall <= '0;
            r_err   <= 1'b0;
          end
        end
        w_run: begin
          if (w_acc || w_ret) r_stall <= '0;
          else                r_stall <= r_stall + SW'(1);
          if (w_timeout) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYCLES != 0);
  assign w_timeout   = 1'b0;
  assign error       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      w_idle: begin
        if (start)
          w_state_nxt = (num_words == '0) ? S_FINISH : S_RUN;
      end
      w_run: begin
        if (w_timeout || w_last) w_state_nxt = S_FINISH;
      end
      w_fin:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr    <= '0;
      r_num     <= '0;
      r_issue   <= '0;
      r_recv    <= '0;
      r_pend    <= '0;
      r_crc     <= '0;
      r_crc_out <= '0;
    end else begin
      unique case (1'b1)
        w_idle: begin
          if (start) begin
            r_addr  <= base_addr;
            r_num   <= num_words;
            r_issue <= '0;
            r_recv  <= '0;
            r_pend  <= '0;
            r_crc   <= 32'hFFFFFFFF;
            if (num_words == '0) r_crc_out <= '0;
          end
        end
        w_run: begin
          if (w_acc) begin
            r_issue <= r_issue + (ADDR_W+1)'(1);
            r_addr  <= r_addr + ADDR_W'(1);
          end
          unique case ({w_acc, w_ret})
            2'b10:   r_pend <= r_pend + 4'd1;
            2'b01:   r_pend <= r_pend - 4'd1;
            default: ;
          endcase
          r_recv <= w_recv_nxt;
          r_crc  <= w_crc_nxt;
          // A timed-out block reports a zero CRC rather than a partial one.
          if (w_timeout)   r_crc_out <= '0;
          else if (w_last) r_crc_out <= ~w_crc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_qsys_mem_crc_reader.sv
// Directed bench for crc_qsys_mem_crc_reader with an Avalon memory model.
// Timeout scenario runs when CRC_QSYS_MEM_CRC_READER_TIMEOUT_EN is defined.
module tb_crc_qsys_mem_crc_reader;

  localparam int AW = 10;
  localparam int MP = 4;
  localparam int TO = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic          busy;
  logic          done;
  logic [31:0]   crc_out;
  logic          error;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic [3:0]    avm_byteenable;
  logic          avm_waitrequest = 1'b0;
  logic [31:0]   avm_readdata = '0;
  logic          avm_readdatavalid = 1'b0;

  int checks = 0;
  int failures = 0;

  crc_qsys_mem_crc_reader #(
    .ADDR_W(AW),
    .MAX_PENDING(MP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .num_words(num_words),
    .busy(busy),
    .done(done),
    .crc_out(crc_out),
    .error(error),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] d;
  } ret_t;

  logic [31:0]   mem [0:(1<<AW)-1];
  ret_t          rq[$];
  logic [AW-1:0] alog[$];
  int  nc = 0;
  int  last_due = 0;
  int  lat_lo = 1;
  int  lat_hi = 1;
  int  m_lat;
  int  m_due;
  int  nreads = 0;
  int  stall_viol = 0;
  int  max_out = 0;
  bit  rand_wait = 0;
  bit  hold_valid = 0;
  bit  log_en = 0;
  bit  mon_en = 0;
  bit  p_stall = 0;
  logic [AW-1:0] p_addr = '0;

  // Memory slave: drives its outputs on the falling edge.
  always @(negedge clk) begin
    nc = nc + 1;
    if (!hold_valid && rq.size() > 0 && rq[0].due <= nc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = rq[0].d;
      rq.delete(0);
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata = 32'h0;
    end
    if (mon_en && !reset && p_stall &&
        (avm_read !== 1'b1 || avm_address !== p_addr))
      stall_viol = stall_viol + 1;
    avm_waitrequest = rand_wait && ($urandom_range(0, 2) == 0);
    p_stall = (avm_read === 1'b1) && avm_waitrequest;
    p_addr = avm_address;
    if (avm_read === 1'b1) nreads = nreads + 1;
    if (avm_read === 1'b1 && !avm_waitrequest) begin
      m_lat = int'($urandom_range(lat_lo, lat_hi));
      m_due = nc + m_lat;
      if (m_due <= last_due) m_due = last_due + 1;
      last_due = m_due;
      rq.push_back('{m_due, mem[avm_address]});
      if (log_en) alog.push_back(avm_address);
    end
    if (rq.size() + int'(avm_readdatavalid) > max_out)
      max_out = rq.size() + int'(avm_readdatavalid);
  end

  function automatic logic [31:0] ref_crc(input int b, input int n);
    logic [31:0] c;
    logic [31:0] w;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++) begin
      w = mem[(b + k) % (1 << AW)];
      for (int j = 0; j < 4; j++) begin
        c = c ^ {24'h0, w[8*j +: 8]};
        for (int t = 0; t < 8; t++)
          c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  task automatic run_xfer(
    input  int b,
    input  int n,
    output int cyc,
    output bit to
  );
    @(posedge clk); #1;
    base_addr = AW'(b);
    num_words = (AW+1)'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    to = (done !== 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    idle_cycles(2);
    checks++;
    if ({busy, done, error, avm_read} !== 4'b0000) begin
      failures++;
      $display("FAIL rst_ctl got=%b want=0000",
               {busy, done, error, avm_read});
    end
    checks++;
    if (crc_out !== 32'h0 || avm_address !== '0) begin
      failures++;
      $display("FAIL rst_data crc=%h addr=%0d want 0/0",
               crc_out, avm_address);
    end
    checks++;
    if (avm_byteenable !== 4'b1111) begin
      failures++;
      $display("FAIL byteen got=%b want=1111", avm_byteenable);
    end
    reset = 1'b0;
  endtask

  task automatic test_len1_1234;
    int cyc;
    bit to;
    mem[0] = 32'h34333231;
    run_xfer(0, 1, cyc, to);
    checks++;
    if (to || cyc != 3) begin
      failures++;
      $display("FAIL len1_lat got=%0d want=3 to=%0d", cyc, to);
    end
    checks++;
    if (crc_out !== 32'h9BE3E0A3) begin
      failures++;
      $display("FAIL len1_crc got=%h want=9be3e0a3", crc_out);
    end
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL len1_err got=%b want=0", error);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL len1_after busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_len0;
    int cyc;
    bit to;
    int n0;
    n0 = nreads;
    run_xfer(17, 0, cyc, to);
    checks++;
    if (to || cyc != 1) begin
      failures++;
      $display("FAIL len0_lat got=%0d want=1 to=%0d", cyc, to);
    end
    checks++;
    if (crc_out !== 32'h0) begin
      failures++;
      $display("FAIL len0_crc got=%h want=00000000", crc_out);
    end
    idle_cycles(3);
    checks++;
    if (nreads != n0) begin
      failures++;
      $display("FAIL len0_reads got=%0d want=%0d", nreads, n0);
    end
  endtask

  task automatic test_len1_zero;
    int cyc;
    bit to;
    mem[5] = 32'h0;
    run_xfer(5, 1, cyc, to);
    checks++;
    if (to || crc_out !== 32'h2144DF1C) begin
      failures++;
      $display("FAIL zero_crc got=%h want=2144df1c to=%0d", crc_out, to);
    end
  endtask

  task automatic test_wrap;
    int cyc;
    bit to;
    logic [AW-1:0] exp_a [4];
    exp_a = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    mem[1022] = 32'hDEADBEEF;
    mem[1023] = 32'h01234567;
    mem[0]    = 32'h89ABCDEF;
    mem[1]    = 32'hCAFEF00D;
    alog.delete();
    log_en = 1;
    run_xfer(1022, 4, cyc, to);
    log_en = 0;
    checks++;
    if (to || cyc != 6) begin
      failures++;
      $display("FAIL wrap_lat got=%0d want=6 to=%0d", cyc, to);
    end
    checks++;
    if (alog.size() != 4) begin
      failures++;
      $display("FAIL wrap_nreq got=%0d want=4", alog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (alog[i] !== exp_a[i]) begin
          failures++;
          $display("FAIL wrap_addr%0d got=%0d want=%0d",
                   i, alog[i], exp_a[i]);
        end
      end
    end
    checks++;
    if (crc_out !== ref_crc(1022, 4)) begin
      failures++;
      $display("FAIL wrap_crc got=%h want=%h",
               crc_out, ref_crc(1022, 4));
    end
  endtask

  task automatic test_random;
    int cyc;
    for (int i = 0; i < 64; i++) mem[100 + i] = $urandom;
    rand_wait = 1;
    lat_lo = 1;
    lat_hi = 3;
    stall_viol = 0;
    max_out = 0;
    mon_en = 1;
    @(posedge clk); #1;
    base_addr = AW'(100);
    num_words = (AW+1)'(64);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 5000) begin
      if (cyc == 10 || cyc == 40) begin
        base_addr = AW'(0);
        num_words = (AW+1)'(3);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    mon_en = 0;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL rand_done got=%b want=1 after %0d", done, cyc);
    end
    checks++;
    if (crc_out !== ref_crc(100, 64)) begin
      failures++;
      $display("FAIL rand_crc got=%h want=%h",
               crc_out, ref_crc(100, 64));
    end
    checks++;
    if (stall_viol != 0) begin
      failures++;
      $display("FAIL rand_stable got=%0d want=0", stall_viol);
    end
    checks++;
    if (max_out > MP || max_out < 1) begin
      failures++;
      $display("FAIL rand_pending got=%0d want=1..%0d", max_out, MP);
    end
    rand_wait = 0;
    lat_lo = 1;
    lat_hi = 1;
    idle_cycles(6);
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit to;
    int late;
    bit stray;
    for (int i = 0; i < 20; i++) mem[200 + i] = $urandom;
    for (int i = 0; i < 5; i++) mem[300 + i] = $urandom;
    lat_lo = 3;
    lat_hi = 3;
    @(posedge clk); #1;
    base_addr = AW'(200);
    num_words = (AW+1)'(20);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idle_cycles(5);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || avm_read !== 1'b0 ||
        crc_out !== 32'h0 || avm_address !== '0) begin
      failures++;
      $display("FAIL mid_rst busy=%b rd=%b crc=%h addr=%0d want 0",
               busy, avm_read, crc_out, avm_address);
    end
    late = 0;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      if (avm_readdatavalid === 1'b1) late++;
      if (busy !== 1'b0 || done !== 1'b0) stray = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (late == 0 || stray) begin
      failures++;
      $display("FAIL mid_late late=%0d stray=%0d want >0/0",
               late, stray);
    end
    lat_lo = 1;
    lat_hi = 1;
    run_xfer(300, 5, cyc, to);
    checks++;
    if (to || cyc != 7) begin
      failures++;
      $display("FAIL mid_lat got=%0d want=7 to=%0d", cyc, to);
    end
    checks++;
    if (crc_out !== ref_crc(300, 5)) begin
      failures++;
      $display("FAIL mid_crc got=%h want=%h",
               crc_out, ref_crc(300, 5));
    end
  endtask

`ifdef CRC_QSYS_MEM_CRC_READER_TIMEOUT_EN
  task automatic test_timeout;
    int cyc;
    bit to;
    hold_valid = 1;
    mem[40] = 32'h11112222;
    mem[41] = 32'h33334444;
    run_xfer(40, 2, cyc, to);
    checks++;
    if (to || cyc != 3 + TO) begin
      failures++;
      $display("FAIL to_lat got=%0d want=%0d to=%0d", cyc, 3 + TO, to);
    end
    checks++;
    if (error !== 1'b1 || crc_out !== 32'h0) begin
      failures++;
      $display("FAIL to_flag err=%b crc=%h want 1/0", error, crc_out);
    end
    hold_valid = 0;
    idle_cycles(6);
    checks++;
    if (busy !== 1'b0 || error !== 1'b1) begin
      failures++;
      $display("FAIL to_idle busy=%b err=%b want 0/1", busy, error);
    end
    mem[0] = 32'h34333231;
    run_xfer(0, 1, cyc, to);
    checks++;
    if (to || error !== 1'b0 || crc_out !== 32'h9BE3E0A3) begin
      failures++;
      $display("FAIL to_next err=%b crc=%h want 0/9be3e0a3",
               error, crc_out);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    test_reset();
    test_len1_1234();
    test_len0();
    test_len1_zero();
    test_wrap();
    test_random();
    test_reset_mid();
`ifdef CRC_QSYS_MEM_CRC_READER_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc_qsys_mem_crc_reader.md
# crc_qsys_mem_crc_reader

Avalon-MM read master that streams a block of 32-bit words out of the on-chip memory and computes their CRC-32. It sits in the Qsys system beside the on-chip memory, driving that memory's slave port through the interconnect. Software or a control FSM supplies a base word address and a length. The block returns the CRC and a done pulse.

## Interface

Parameters:
- ADDR_W, 10, word-address width; matches the 1024-word on-chip memory.
- MAX_PENDING, 4, maximum outstanding reads (1..15).
- TIMEOUT_CYCLES, 256, stall limit; used only with the configuration macro.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; captured on accepted start.
- num_words  in  ADDR_W+1  word count, 0..2^ADDR_W; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- crc_out  out  32  final CRC; valid with done and held until the next accepted start.
- error  out  1  timeout flag; set with done, cleared on the next accepted start.
- avm_address  out  ADDR_W  word address.
- avm_read  out  1  read request.
- avm_byteenable  out  4  constant 4'b1111.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  readdata qualifier.

## Operation

- States: IDLE, RUN, FINISH.
- IDLE, start=1, num_words>0:
  - capture base_addr and num_words
  - issue_cnt = 0, recv_cnt = 0, crc = 0xFFFFFFFF, error = 0
  - go to RUN
- IDLE, start=1, num_words=0: go directly to FINISH; crc_out = 0x00000000.
- RUN, issue side:
  - assert avm_read while issue_cnt < num_words and pending < MAX_PENDING.
  - avm_address = base + issue_cnt, modulo 2^ADDR_W; wraps from the top word to 0.
  - a read is accepted when avm_read=1 and avm_waitrequest=0; then issue_cnt++ and pending++.
  - while avm_waitrequest=1, avm_read and avm_address stay stable.
- RUN, return side:
  - each avm_readdatavalid decrements pending and increments recv_cnt.
  - the returned word is folded into the CRC.
  - a read accepted in the same cycle as a returned word leaves pending unchanged.
- When recv_cnt == num_words: go to FINISH.
- FINISH:
  - crc_out = crc ^ 0xFFFFFFFF
  - done = 1 for one cycle
  - busy = 0
  - go to IDLE
- CRC arithmetic:
  - IEEE CRC-32, reflected polynomial 0xEDB88320.
  - 32 bits per cycle; byte order readdata[7:0] first, then [15:8], [23:16], [31:24]; LSB first within each byte.
- start while busy: ignored.
- avm_readdatavalid in IDLE: ignored.
- Reset (any state, mid-transfer included):
  - go to IDLE
  - busy, done, error, avm_read = 0
  - crc_out = 0, avm_address = 0, all counters = 0
  - returns still in flight after reset are discarded, because they arrive in IDLE.

## Timing

- Start-to-first-read: the first avm_read is asserted the cycle after start.
- Zero wait states: one read accepted per cycle, up to MAX_PENDING outstanding.
- Memory with 1-cycle read latency and MAX_PENDING ≥ 2: N words complete in N+3 cycles from start to done.
- done rises the cycle after the last avm_readdatavalid.
- crc_out updates in the same cycle that done is asserted.

## Configuration

- Macro: CRC_QSYS_MEM_CRC_READER_TIMEOUT_EN.
- Defined:
  - in RUN, a stall counter resets on every accepted read or returned word, and increments otherwise.
  - when it reaches TIMEOUT_CYCLES: avm_read drops, the block goes to FINISH with error = 1 and crc_out = 0x00000000.
  - outstanding returns arriving later are ignored.
- Not defined:
  - no stall counter; error is tied to 0.
  - the block waits indefinitely for returns.

## Test plan

- Length 1 at base 0; memory word 0x34333231 ("1234") -> done with crc_out = 0x9BE3E0A3, busy low afterwards.
- Length 1; word 0x00000000 -> crc_out = 0x2144DF1C.
- Length 0 -> no avm_read ever asserted; done two cycles after start; crc_out = 0x00000000.
- base_addr = 1022, length 4 -> addresses issued in order 1022, 1023, 0, 1; CRC matches the reference model.
- Random avm_waitrequest and 1–3-cycle random return latency, length 64:
  - address and read held stable while stalled
  - pending never exceeds MAX_PENDING
  - CRC matches the model
  - start pulses during busy have no effect
- Reset asserted mid-transfer, followed by a new start:
  - the late readdatavalid is ignored
  - the second CRC is correct
- With the macro defined: avm_readdatavalid withheld -> done and error = 1 exactly TIMEOUT_CYCLES cycles after the last progress event.
